// File: rtl/cia_bus_master.sv
// CPU-side initiator for the CIA register bus: free-running PHI2, /RES sequencing and
// single 6502-style read/write cycles launched from a valid/ready request port.
module cia_bus_master #(
    parameter int unsigned PHI2_HALF  = 12,
    parameter int unsigned RES_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_req,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       phi2,
    output logic       res_n,
    output logic       cs_n,
    output logic       r_w_n,
    output logic [3:0] addr,
    output logic [7:0] data_o,
    output logic       data_oe,
    input  logic [7:0] data_i
);

    localparam int unsigned DivW  = (PHI2_HALF > 1) ? $clog2(PHI2_HALF) : 1;
    localparam int unsigned RcntW = $clog2(RES_CYCLES + 1);
    localparam logic [DivW-1:0]  DivMax   = DivW'(PHI2_HALF - 1);
    localparam logic [RcntW-1:0] RcntLast = RcntW'(RES_CYCLES - 1);

    typedef enum logic [1:0] {StReset, StIdle, StWait, StCycle} state_e;

    state_e           state_q, state_d;
    logic [DivW-1:0]  div_q, div_d;
    logic             phi2_q, phi2_d;
    logic [RcntW-1:0] rcnt_q, rcnt_d;
    logic             res_n_q, res_n_d;
    logic             cs_n_q, cs_n_d;
    logic             r_w_n_q, r_w_n_d;
    logic [3:0]       addr_q, addr_d;
    logic [7:0]       data_o_q, data_o_d;
    logic             data_oe_q, data_oe_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic             lat_we_q, lat_we_d;
    logic [3:0]       lat_addr_q, lat_addr_d;
    logic [7:0]       lat_wdata_q, lat_wdata_d;

    logic tick, rise, fall, accept;

    // PHI2 divider runs in every state, including while /RES is held low
    assign tick   = (div_q == DivMax);
    assign rise   = tick & ~phi2_q;
    assign fall   = tick & phi2_q;
    assign div_d  = tick ? '0 : div_q + 1'b1;
    assign phi2_d = phi2_q ^ tick;

    assign req_ready = (state_q == StIdle) & ~rst_req;
    assign accept    = req_valid & req_ready;

    // State register and all output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StReset;
            div_q       <= '0;
            phi2_q      <= 1'b0;
            rcnt_q      <= '0;
            res_n_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            r_w_n_q     <= 1'b1;
            addr_q      <= 4'h0;
            data_o_q    <= 8'h00;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= 4'h0;
            lat_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            phi2_q      <= phi2_d;
            rcnt_q      <= rcnt_d;
            res_n_q     <= res_n_d;
            cs_n_q      <= cs_n_d;
            r_w_n_q     <= r_w_n_d;
            addr_q      <= addr_d;
            data_o_q    <= data_o_d;
            data_oe_q   <= data_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: begin
                if (fall && (rcnt_q == RcntLast)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (rst_req) begin
                    state_d = StReset;
                end else if (accept) begin
                    state_d = StWait;
                end
            end
            // A fall on the accepting edge is not seen here, so launch waits for the next one
            StWait: begin
                if (fall) begin
                    state_d = StCycle;
                end
            end
            StCycle: begin
                if (fall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StReset;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        rcnt_d      = rcnt_q;
        res_n_d     = res_n_q;
        cs_n_d      = cs_n_q;
        r_w_n_d     = r_w_n_q;
        addr_d      = addr_q;
        data_o_d    = data_o_q;
        data_oe_d   = data_oe_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        case (state_q)
            StReset: begin
                res_n_d = 1'b0;
                cs_n_d  = 1'b1;
                if (fall) begin
                    rcnt_d = rcnt_q + 1'b1;
                    if (rcnt_q == RcntLast) begin
                        res_n_d = 1'b1;
                    end
                end
            end
            StIdle: begin
                if (rst_req) begin
                    res_n_d = 1'b0;
                    rcnt_d  = '0;
                end else if (accept) begin
                    lat_we_d    = req_we;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                end
            end
            StWait: begin
                if (fall) begin
                    cs_n_d  = 1'b0;
                    r_w_n_d = ~lat_we_q;
                    addr_d  = lat_addr_q;
                    if (lat_we_q) begin
                        data_o_d = lat_wdata_q;
                    end
                end
            end
            StCycle: begin
                // Write data is driven only while PHI2 is high
                if (rise && lat_we_q) begin
                    data_oe_d = 1'b1;
                end
                if (fall) begin
                    cs_n_d      = 1'b1;
                    r_w_n_d     = 1'b1;
                    data_oe_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lat_we_q ? 8'h00 : data_i;
                end
            end
            default: ;
        endcase
    end

    assign phi2      = phi2_q;
    assign res_n     = res_n_q;
    assign cs_n      = cs_n_q;
    assign r_w_n     = r_w_n_q;
    assign addr      = addr_q;
    assign data_o    = data_o_q;
    assign data_oe   = data_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_cia_bus_master.sv
// Bench for cia_bus_master: vector table of bus cycles with a response scoreboard,
// plus hand sequences for reset length, mid-cycle rst and rst_req/req_valid collision.
module tb_cia_bus_master;

    localparam int Half = 12;
    localparam int Per  = 2 * Half;
    localparam int ResClks = 10 * Per;

    logic       clk;
    logic       rst;
    logic       rst_req;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       phi2;
    logic       res_n;
    logic       cs_n;
    logic       r_w_n;
    logic [3:0] addr;
    logic [7:0] data_o;
    logic       data_oe;
    logic [7:0] data_i;

    cia_bus_master #(
        .PHI2_HALF (Half),
        .RES_CYCLES(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rst_req  (rst_req),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .phi2     (phi2),
        .res_n    (res_n),
        .cs_n     (cs_n),
        .r_w_n    (r_w_n),
        .addr     (addr),
        .data_o   (data_o),
        .data_oe  (data_oe),
        .data_i   (data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [3:0] a;
        logic [7:0] wd;
        logic [7:0] rd;        // value the CIA model drives during PHI2 high
        int         phase;     // accept edge position within the PHI2 period
        int         exp_lat;   // accept -> cs_n low, in clks
        int         exp_oe;    // clks with data_oe high
        logic [7:0] exp_rdata;
    } vec_t;

    int         n_total = 0;
    int         n_pass  = 0;
    int         k       = 0;   // clk edges since last rst edge
    int         phi_err = 0;
    int         unexp   = 0;
    int         rsp_cnt = 0;
    bit         chk_phi = 0;
    logic [7:0] bus_rd  = 8'hEE;
    logic [7:0] sb_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic exp_phi(input int kk);
        return ((kk / Half) % 2) == 1;
    endfunction

    // One clk: advance, drive the CIA read model, check PHI2 and score responses
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (rst) k = 0;
        else k++;
        data_i = phi2 ? bus_rd : 8'hEE;
        if (chk_phi && (phi2 !== exp_phi(k))) phi_err++;
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            if (sb_q.size() == 0) unexp++;
            else begin
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e);
            end
        end
    endtask

    // Counts clks of res_n low starting at the current observation
    task automatic wait_res_high(output int low, output int bad);
        low = 0;
        bad = 0;
        while (res_n === 1'b0 && low < 1000) begin
            low++;
            if (cs_n !== 1'b1 || req_ready !== 1'b0) bad++;
            tick();
        end
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int waited, k_acc, lat, exp_lat, low, oe, bad, rsp0;
        if (v.phase >= 0) begin
            waited = 0;
            while (((k + 1) % Per) != v.phase && waited < 100) begin
                tick();
                waited++;
            end
        end
        req_we    = v.we;
        req_addr  = v.a;
        req_wdata = v.wd;
        req_valid = 1'b1;
        bus_rd    = v.rd;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < 1000) begin
            tick();
            waited++;
        end
        check({nm, "_ready"}, req_ready, 1'b1);
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        sb_q.push_back(v.exp_rdata);
        rsp0 = rsp_cnt;
        tick();
        k_acc     = k;
        req_valid = 1'b0;
        exp_lat   = (v.exp_lat >= 0) ? v.exp_lat : Per - (k_acc % Per);
        lat = 0;
        while (cs_n === 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        check({nm, "_latency"}, lat, exp_lat);
        low = 0;
        oe  = 0;
        bad = 0;
        while (cs_n === 1'b0 && low < 60) begin
            low++;
            if (r_w_n !== !v.we || addr !== v.a) bad++;
            if (data_oe === 1'b1) begin
                oe++;
                if (data_o !== v.wd || phi2 !== 1'b1) bad++;
            end
            tick();
        end
        check({nm, "_cs_low_clks"}, low, Per);
        check({nm, "_oe_clks"}, oe, v.exp_oe);
        check({nm, "_bus_errs"}, bad, 0);
        check({nm, "_end_rw_oe"}, {r_w_n, data_oe}, 2'b10);
        tick();
        check({nm, "_rsp_count"}, rsp_cnt - rsp0, 1);
    endtask

    vec_t vecs[6];

    initial begin
        int low, bad, k_r, f10, waited;
        vec_t v;

        // we, addr, wdata, rd, phase, exp_lat, exp_oe, exp_rdata
        vecs[0] = '{1'b1, 4'h4, 8'h34, 8'h5A, 5,  19, 12, 8'h00};
        vecs[1] = '{1'b0, 4'hD, 8'h11, 8'h81, 0,  24, 0,  8'h81};
        vecs[2] = '{1'b1, 4'hF, 8'hA5, 8'h5A, 23, 1,  12, 8'h00};
        vecs[3] = '{1'b0, 4'h0, 8'h22, 8'h3C, 12, 12, 0,  8'h3C};
        vecs[4] = '{1'b0, 4'h7, 8'h33, 8'hFF, 1,  23, 0,  8'hFF};
        vecs[5] = '{1'b1, 4'h9, 8'h00, 8'hC3, 18, 6,  12, 8'h00};

        rst       = 1'b1;
        rst_req   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
        data_i    = 8'hEE;
        tick();
        tick();
        chk_phi = 1;
        check("rst_phi2", phi2, 1'b0);
        check("rst_res_n", res_n, 1'b0);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_r_w_n", r_w_n, 1'b1);
        check("rst_addr", addr, 4'h0);
        check("rst_data_o", data_o, 8'h00);
        check("rst_data_oe", data_oe, 1'b0);
        check("rst_rsp", {rsp_valid, rsp_rdata}, 9'h000);
        check("rst_ready", req_ready, 1'b0);
        rst = 1'b0;
        wait_res_high(low, bad);
        check("res_low_clks", low, ResClks);
        check("res_bus_quiet", bad, 0);
        check("ready_after_res", req_ready, 1'b1);

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // rst during the high phase of a write aborts with no response
        req_we    = 1'b1;
        req_addr  = 4'h3;
        req_wdata = 8'hC3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        waited = 0;
        while (data_oe !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        check("abort_oe_seen", data_oe, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", {cs_n, data_oe, res_n, rsp_valid}, 4'b1000);
        wait_res_high(low, bad);
        check("abort_res_low_clks", low, ResClks);
        check("abort_bus_quiet", bad, 0);

        // rst_req collides with req_valid in IDLE: reset wins, request taken afterwards
        repeat (5) tick();
        v = '{1'b1, 4'h2, 8'h77, 8'h5A, -1, -1, 12, 8'h00};
        req_we    = v.we;
        req_addr  = v.a;
        req_wdata = v.wd;
        req_valid = 1'b1;
        rst_req   = 1'b1;
        #1;
        check("collide_ready", req_ready, 1'b0);
        tick();
        rst_req = 1'b0;
        k_r = k;
        f10 = (k_r / Per + 1) * Per + 9 * Per;
        check("collide_res_n", res_n, 1'b0);
        wait_res_high(low, bad);
        check("collide_res_low_clks", low, f10 - k_r);
        check("collide_no_cycle", bad, 0);
        run_txn(v, "collide_txn");

        check("phi2_errs", phi_err, 0);
        check("unexpected_rsp", unexp, 0);
        check("sb_left", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
